fetch_stage: RTL and testbench

- Instruction fetch front end. Produces the instruction/PC stream that the decode stage consumes.
- Issues sequential word requests to instruction memory over a valid/ready request channel and accepts in-order responses of variable latency.
- Buffers fetched words in a small prefetch queue and presents them to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing the queue and discarding in-flight stale responses.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch front end: sequential word requests to instruction memory,
// a small prefetch queue, and a valid/ready instruction stream toward decode.
// Redirects flush the queue and discard responses to requests already in flight.

package fetch_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;
endpackage

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_out
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_entry_t     queue_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_count_q, drop_count_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;

  logic         not_empty;
  logic         req_fire;
  logic         push;
  logic         pop;
  fetch_entry_t head;

  // Request credits, head presentation and handshake qualifiers
  always_comb begin
    not_empty      = (count_q != '0);
    head           = queue_q[rd_ptr_q];
    imem_req_valid = reset_n && !redirect_valid
                     && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                     && ((32'(outstanding_q) + 32'(count_q)) < 32'(QUEUE_DEPTH));
    imem_req_addr  = fetch_pc_q;
    instr_valid    = reset_n && !redirect_valid && not_empty;
    instruction    = (reset_n && not_empty) ? head.data : NOP;
    pc_out         = (reset_n && not_empty) ? head.pc : 32'h0000_0000;
    req_fire       = imem_req_valid && imem_req_ready;
    push           = reset_n && imem_rsp_valid && !redirect_valid && (drop_count_q == '0);
    pop            = instr_valid && instr_ready;
  end

  // Next-state for pointers, counters and fetch/response PCs
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid);
    drop_count_d  = drop_count_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;

    if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the old stream
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      drop_count_d = outstanding_q - OUT_W'(imem_rsp_valid);
      fetch_pc_d   = {redirect_pc[31:2], 2'b00};
      rsp_pc_d     = {redirect_pc[31:2], 2'b00};
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_count_q != '0)) begin
        drop_count_d = drop_count_q - OUT_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_count_q  <= '0;
      fetch_pc_q    <= RESET_PC_ALIGNED;
      rsp_pc_q      <= RESET_PC_ALIGNED;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
    end
  end

  // Queue storage; contents are only meaningful below count_q
  always_ff @(posedge clk) begin
    if (push) begin
      queue_q[wr_ptr_q] <= '{pc: rsp_pc_q, data: imem_rsp_data};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order fixed-latency memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] XMSK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  fetch_stage #(
    .RESET_PC       (32'h0000_0000),
    .QUEUE_DEPTH    (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .pc_out        (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        exp_iv;
    logic [31:0] exp_pc;
    logic        exp_rv;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Record this cycle's handshake, cross the edge, present the next cycle's response
  task automatic tick();
    #1;
    if (reset_n && imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + mem_lat);
    end
    @(posedge clk);
    if (!reset_n) begin
      pend_addr.delete();
      pend_due.delete();
    end
    @(negedge clk);
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_addr[0] ^ XMSK;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int max_cyc, output int n);
    n = 0;
    #1;
    while (!instr_valid && n < max_cyc) begin
      tick();
      #1;
      n++;
    end
    check({name, " wait"}, 32'(instr_valid), 32'd1);
  endtask

  function automatic void add(input logic r, input logic rd, input logic iv,
                              input logic [31:0] pc, input logic rv, input logic [31:0] a);
    vec_t v;
    v.rst_n = r; v.rdy = rd; v.exp_iv = iv; v.exp_pc = pc; v.exp_rv = rv; v.exp_addr = a;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n        = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;

    // Streaming from reset, then back-pressure fill from a second reset
    add(0, 1, 0, 32'h00, 0, 32'h00);
    add(1, 1, 0, 32'h00, 1, 32'h00);
    add(1, 1, 0, 32'h00, 1, 32'h04);
    add(1, 1, 1, 32'h00, 1, 32'h08);
    add(1, 1, 1, 32'h04, 1, 32'h0C);
    add(1, 1, 1, 32'h08, 1, 32'h10);
    add(1, 1, 1, 32'h0C, 1, 32'h14);
    add(0, 0, 0, 32'h00, 0, 32'h00);
    add(1, 0, 0, 32'h00, 1, 32'h00);
    add(1, 0, 0, 32'h00, 1, 32'h04);
    add(1, 0, 1, 32'h00, 1, 32'h08);
    add(1, 0, 1, 32'h00, 1, 32'h0C);
    for (int k = 0; k < 6; k++) add(1, 0, 1, 32'h00, 0, 32'h00);
    add(1, 1, 1, 32'h00, 0, 32'h00);
    add(1, 1, 1, 32'h04, 1, 32'h10);
    add(1, 1, 1, 32'h08, 1, 32'h14);
    add(1, 1, 1, 32'h0C, 1, 32'h18);
    add(1, 1, 1, 32'h10, 1, 32'h1C);
    add(1, 1, 1, 32'h14, 1, 32'h20);

    for (int i = 0; i < vecs.size(); i++) begin
      reset_n     = vecs[i].rst_n;
      instr_ready = vecs[i].rdy;
      #1;
      check($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_iv));
      check($sformatf("row%0d pc_out", i), pc_out, vecs[i].exp_iv ? vecs[i].exp_pc : 32'h0);
      check($sformatf("row%0d instruction", i), instruction,
            vecs[i].exp_iv ? (vecs[i].exp_pc ^ XMSK) : NOP);
      check($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].exp_rv)
        check($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].exp_addr);
      tick();
    end

    // Two stale responses in flight at latency 3 are discarded
    mem_lat = 3; instr_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    #1;
    check("s3 redirect no req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    #1;
    check("s3 credit stall", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("s3 c4 instr_valid", 32'(instr_valid), 32'd0);
    check("s3 c4 req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    #1;
    check("s3 c5 req_valid", 32'(imem_req_valid), 32'd1);
    check("s3 c5 req_addr", imem_req_addr, 32'h200);
    wait_valid("s3", 20, n);
    check("s3 latency", 32'(n), 32'd4);
    check("s3 pc_out", pc_out, 32'h200);
    check("s3 instruction", instruction, 32'hA5A5_0200);

    // Redirect coinciding with a response, one more request outstanding
    mem_lat = 2;
    do_reset();
    tick();
    tick();
    #1;
    check("s4 rsp present", 32'(imem_rsp_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("s4 queue empty", 32'(instr_valid), 32'd0);
    check("s4 req_valid", 32'(imem_req_valid), 32'd1);
    check("s4 req_addr", imem_req_addr, 32'h80);
    tick();
    #1;
    check("s4 stale dropped", 32'(instr_valid), 32'd0);
    wait_valid("s4", 20, n);
    check("s4 latency", 32'(n), 32'd2);
    check("s4 pc_out", pc_out, 32'h80);
    check("s4 instruction", instruction, 32'hA5A5_0080);

    // Back-to-back redirects with two requests in flight
    mem_lat = 3;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("s5 req_valid", 32'(imem_req_valid), 32'd1);
    check("s5 req_addr", imem_req_addr, 32'h300);
    check("s5 instr_valid", 32'(instr_valid), 32'd0);
    wait_valid("s5", 20, n);
    check("s5 latency", 32'(n), 32'd4);
    check("s5 pc_out", pc_out, 32'h300);
    check("s5 instruction", instruction, 32'hA5A5_0300);

    // Reset with a full queue, then memory stalling the first request
    mem_lat = 1;
    do_reset();
    instr_ready = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    #1;
    check("s6 full head", pc_out, 32'h0);
    check("s6 full req_valid", 32'(imem_req_valid), 32'd0);
    reset_n = 1'b0;
    #1;
    check("s6 rst instr_valid", 32'(instr_valid), 32'd0);
    check("s6 rst instruction", instruction, NOP);
    tick();
    reset_n = 1'b1; instr_ready = 1'b1; imem_req_ready = 1'b0;
    #1;
    check("s6 post instr_valid", 32'(instr_valid), 32'd0);
    check("s6 post instruction", instruction, NOP);
    check("s6 post pc_out", pc_out, 32'h0);
    check("s6 post req_valid", 32'(imem_req_valid), 32'd1);
    check("s6 post req_addr", imem_req_addr, 32'h0);
    tick();
    #1;
    check("s6 hold req_valid", 32'(imem_req_valid), 32'd1);
    check("s6 hold req_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    #1;
    check("s6 next req_addr", imem_req_addr, 32'h4);
    wait_valid("s6", 20, n);
    check("s6 pc_out", pc_out, 32'h0);
    check("s6 instruction", instruction, 32'hA5A5_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
